pin_entry_controller: RTL and testbench

Keypad-side front end for the combination lock: collects four hex key presses into a 16-bit PIN and presents it to the lock state machine with a fixed-width `trig` pulse. It is the initiator of the `pinCode`/`trig` interface that the lock consumes. It also handles clear, inactivity timeout, short-entry errors and inhibit from the lock side.

---
 rtl/pin_entry_controller.sv | 144 ++++++++++++++
 tb/tb_pin_entry_controller.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pin_entry_controller.sv
// Keypad front end for the combination lock: gathers four hex digits into a PIN
// and submits it to the lock with a fixed-width trig pulse, then wipes it.
module pin_entry_controller #(
    parameter int TRIG_CYCLES = 3,
    parameter int HOLDOFF     = 4,
    parameter int TIMEOUT     = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        keyValid,
    input  logic [3:0]  keyCode,
    input  logic        keyEnter,
    input  logic        keyClear,
    input  logic        inhibit,
    output logic [15:0] pinCode,
    output logic        trig,
    output logic [2:0]  digitCount,
    output logic        entryErr
);
    localparam int TRW = $clog2(TRIG_CYCLES) + 1;
    localparam int HOW = $clog2(HOLDOFF) + 1;
    localparam int TOW = $clog2(TIMEOUT) + 1;
    localparam logic [TRW-1:0] TRIG_LAST = TRW'(TRIG_CYCLES - 1);
    localparam logic [HOW-1:0] HOLD_LAST = HOW'(HOLDOFF - 1);
    localparam logic [TOW-1:0] TO_LAST   = TOW'(TIMEOUT - 1);
    localparam logic [TOW-1:0] TO_MAX    = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_FULL,
        S_SEND,
        S_HOLD
    } state_t;

    state_t          r_state, w_state_next;
    logic [15:0]     r_pin, w_pin_next;
    logic [2:0]      r_count, w_count_next;
    logic            r_err, w_err_next;
    logic            r_trig;
    logic            r_kv_q, r_en_q;
    logic [TRW-1:0]  r_trig_cnt, w_trig_cnt_next;
    logic [HOW-1:0]  r_hold_cnt, w_hold_cnt_next;
    logic [TOW-1:0]  r_to_cnt, w_to_cnt_next;
    logic            w_key_press, w_enter_press, w_timeout;

    assign w_key_press   = keyValid & ~r_kv_q;
    assign w_enter_press = keyEnter & ~r_en_q;
    assign w_timeout     = (r_to_cnt >= TO_LAST);

    always_comb begin
        w_state_next    = r_state;
        w_pin_next      = r_pin;
        w_count_next    = r_count;
        w_err_next      = 1'b0;
        w_trig_cnt_next = r_trig_cnt;
        w_hold_cnt_next = r_hold_cnt;
        w_to_cnt_next   = '0;
        case (r_state)
            S_IDLE, S_COLLECT, S_FULL: begin
                if (r_state != S_IDLE)
                    w_to_cnt_next = (r_to_cnt == TO_MAX) ? r_to_cnt : r_to_cnt + 1'b1;
                // Timeout behaves exactly like a clear, so it shares the top priority slot.
                if (keyClear || (r_state != S_IDLE && w_timeout)) begin
                    w_pin_next    = '0;
                    w_count_next  = '0;
                    w_to_cnt_next = '0;
                    w_state_next  = S_IDLE;
                end else if (!inhibit && w_enter_press) begin
                    if (r_state == S_FULL) begin
                        w_state_next    = S_SEND;
                        w_trig_cnt_next = '0;
                        w_to_cnt_next   = '0;
                    end else begin
                        w_err_next = 1'b1;
                    end
                end else if (!inhibit && w_key_press) begin
                    if (r_state == S_FULL) begin
                        w_err_next = 1'b1;
                    end else begin
                        w_pin_next    = {r_pin[11:0], keyCode};
                        w_count_next  = r_count + 3'd1;
                        w_to_cnt_next = '0;
                        w_state_next  = (r_count == 3'd3) ? S_FULL : S_COLLECT;
                    end
                end
            end
            S_SEND: begin
                if (r_trig_cnt == TRIG_LAST) begin
                    w_state_next    = S_HOLD;
                    w_hold_cnt_next = '0;
                end else begin
                    w_trig_cnt_next = r_trig_cnt + 1'b1;
                end
            end
            S_HOLD: begin
                if (r_hold_cnt == HOLD_LAST) begin
                    w_state_next = S_IDLE;
                    w_pin_next   = '0;
                    w_count_next = '0;
                end else begin
                    w_hold_cnt_next = r_hold_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_pin_next   = '0;
                w_count_next = '0;
            end
        endcase
    end

    // Edge registers reset high so a key held through reset release is not a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pin      <= '0;
            r_count    <= '0;
            r_err      <= 1'b0;
            r_trig     <= 1'b0;
            r_kv_q     <= 1'b1;
            r_en_q     <= 1'b1;
            r_trig_cnt <= '0;
            r_hold_cnt <= '0;
            r_to_cnt   <= '0;
        end else begin
            r_state    <= w_state_next;
            r_pin      <= w_pin_next;
            r_count    <= w_count_next;
            r_err      <= w_err_next;
            r_trig     <= (w_state_next == S_SEND);
            r_kv_q     <= keyValid;
            r_en_q     <= keyEnter;
            r_trig_cnt <= w_trig_cnt_next;
            r_hold_cnt <= w_hold_cnt_next;
            r_to_cnt   <= w_to_cnt_next;
        end
    end

    assign pinCode    = r_pin;
    assign trig       = r_trig;
    assign digitCount = r_count;
    assign entryErr   = r_err;
endmodule

// File: tb/tb_pin_entry_controller.sv
// Scoreboard bench for pin_entry_controller: a digit-list reference model predicts
// every cycle's outputs and every submitted PIN; a monitor compares the DUT.
module tb_pin_entry_controller;
    localparam int TRIG_CYCLES = 3;
    localparam int HOLDOFF     = 4;
    localparam int TIMEOUT     = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        keyValid = 1'b0;
    logic [3:0]  keyCode = 4'h0;
    logic        keyEnter = 1'b0;
    logic        keyClear = 1'b0;
    logic        inhibit = 1'b0;
    logic [15:0] pinCode;
    logic        trig;
    logic [2:0]  digitCount;
    logic        entryErr;

    pin_entry_controller #(
        .TRIG_CYCLES(TRIG_CYCLES),
        .HOLDOFF(HOLDOFF),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .keyValid(keyValid),
        .keyCode(keyCode),
        .keyEnter(keyEnter),
        .keyClear(keyClear),
        .inhibit(inhibit),
        .pinCode(pinCode),
        .trig(trig),
        .digitCount(digitCount),
        .entryErr(entryErr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pin;
        logic [2:0]  cnt;
        logic        trig;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] sub_q[$];
    int          errors = 0;
    int          checks = 0;
    int          n_submits = 0;
    int          n_rises = 0;

    // Reference model: the entry is a list of digits; sending/holding are countdowns.
    int m_digits[$];
    int m_mode = 0;   // 0 entry, 1 sending, 2 holding
    int m_rem = 0;
    int m_idle = 0;
    bit m_kv_prev = 1'b1;
    bit m_en_prev = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [15:0] m_pin();
        logic [15:0] p = 16'h0;
        foreach (m_digits[i]) p = (p << 4) | 16'(m_digits[i]);
        return p;
    endfunction

    task automatic model_reset();
        m_digits.delete();
        m_mode = 0;
        m_rem = 0;
        m_idle = 0;
        m_kv_prev = 1'b1;
        m_en_prev = 1'b1;
    endtask

    task automatic model_step(input bit kv, input logic [3:0] code, input bit en,
                              input bit clr, input bit inh);
        bit   press, enter, err;
        exp_t e;
        press = kv && !m_kv_prev;
        enter = en && !m_en_prev;
        m_kv_prev = kv;
        m_en_prev = en;
        err = 1'b0;
        if (m_mode == 0) begin
            if (m_digits.size() > 0) m_idle++;
            if (clr || (m_digits.size() > 0 && m_idle >= TIMEOUT)) begin
                m_digits.delete();
                m_idle = 0;
            end else if (!inh && enter) begin
                if (m_digits.size() == 4) begin
                    m_mode = 1;
                    m_rem = TRIG_CYCLES;
                    m_idle = 0;
                    sub_q.push_back(m_pin());
                    n_submits++;
                end else begin
                    err = 1'b1;
                end
            end else if (!inh && press) begin
                if (m_digits.size() == 4) err = 1'b1;
                else begin
                    m_digits.push_back(int'(code));
                    m_idle = 0;
                end
            end
        end else if (m_mode == 1) begin
            m_rem--;
            if (m_rem == 0) begin
                m_mode = 2;
                m_rem = HOLDOFF;
            end
        end else begin
            m_rem--;
            if (m_rem == 0) begin
                m_mode = 0;
                m_digits.delete();
                m_idle = 0;
            end
        end
        e.pin  = m_pin();
        e.cnt  = 3'(m_digits.size());
        e.trig = (m_mode == 1);
        e.err  = err;
        exp_q.push_back(e);
    endtask

    task automatic cycle(input bit kv, input logic [3:0] code, input bit en,
                         input bit clr, input bit inh);
        @(negedge clk);
        keyValid = kv;
        keyCode  = code;
        keyEnter = en;
        keyClear = clr;
        inhibit  = inh;
        model_step(kv, code, en, clr, inh);
    endtask

    task automatic press(input logic [3:0] d);
        cycle(1'b1, d, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic enter();
        cycle(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    endtask

    // Asserts reset between edges and checks the outputs fall without a clock edge.
    task automatic do_reset(input bit hold_kv);
        @(posedge clk);
        #3;
        rst_n    = 1'b0;
        keyValid = hold_kv;
        keyEnter = 1'b0;
        keyClear = 1'b0;
        inhibit  = 1'b0;
        #1;
        chk("async_rst_pinCode", 32'(pinCode), 32'h0);
        chk("async_rst_trig", 32'(trig), 32'h0);
        chk("async_rst_digitCount", 32'(digitCount), 32'h0);
        chk("async_rst_entryErr", 32'(entryErr), 32'h0);
        @(posedge clk);
        #3;
        model_reset();
        rst_n = 1'b1;
    endtask

    // Monitor: every clock the DUT presents a new output word; trig rising presents a submission.
    initial begin
        logic prev_trig;
        exp_t e;
        prev_trig = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pinCode", 32'(pinCode), 32'(e.pin));
                chk("digitCount", 32'(digitCount), 32'(e.cnt));
                chk("trig", 32'(trig), 32'(e.trig));
                chk("entryErr", 32'(entryErr), 32'(e.err));
                if (trig && !prev_trig) begin
                    n_rises++;
                    if (sub_q.size() > 0) chk("submit_pin", 32'(pinCode), 32'(sub_q.pop_front()));
                    $display("submit pin=%h at t=%0t", pinCode, $time);
                end
                prev_trig = trig;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        chk("reset_pinCode", 32'(pinCode), 32'h0);
        chk("reset_trig", 32'(trig), 32'h0);
        chk("reset_digitCount", 32'(digitCount), 32'h0);
        chk("reset_entryErr", 32'(entryErr), 32'h0);
        @(posedge clk);
        #3;
        model_reset();
        rst_n = 1'b1;

        // 1: full entry and submission
        press(4'hA); press(4'hB); press(4'hC); press(4'hD);
        enter();
        idle(10);
        // 2: fifth digit rejected, enter still submits
        press(4'hA); press(4'hB); press(4'hC); press(4'hD);
        press(4'hE);
        enter();
        idle(10);
        // 3: short entry
        press(4'hB); press(4'hA);
        enter();
        cycle(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        // 4: clear wins over a simultaneous digit
        press(4'hC); press(4'hA);
        cycle(1'b1, 4'h5, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 4'h5, 1'b0, 1'b0, 1'b0);
        // 5: timeout
        press(4'hD);
        idle(20);
        // 6a: inhibit
        press(4'h1);
        cycle(1'b1, 4'hF, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 4'hF, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 4'h0, 1'b0, 1'b1, 1'b1);
        // 6b: reset mid-SEND
        press(4'h1); press(4'h2); press(4'h3); press(4'h4);
        cycle(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        do_reset(1'b0);
        // 6c: key held across reset release
        do_reset(1'b1);
        cycle(1'b1, 4'h7, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 4'h8, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 4'h8, 1'b0, 1'b0, 1'b0);
        press(4'h9);
        cycle(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bit kv, en, clr, inh;
            logic [3:0] code;
            kv   = 1'($urandom_range(0, 1));
            code = 4'($urandom);
            en   = ($urandom_range(0, 5) == 0);
            clr  = ($urandom_range(0, 39) == 0);
            inh  = ($urandom_range(0, 9) == 0);
            cycle(kv, code, en, clr, inh);
            if (i == 1500) do_reset(1'($urandom_range(0, 1)));
        end
        idle(12);
        @(posedge clk);
        #3;
        chk("submit_count", 32'(n_rises), 32'(n_submits));
        chk("pending_submits", 32'(sub_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
